// File: rtl/dcache_mem_sequencer.sv
// Dual-lane M-stage data cache sequencer: serialises lookups, runs writeback/refill
// bursts against main memory and produces stallm plus the cache write enables.
module dcache_mem_sequencer #(
  parameter int MEM_LAT = 20,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic memtoregm,
  input  logic memwritem,
  input  logic memtoregm2,
  input  logic memwritem2,
  input  logic hit,
  input  logic dirty,
  output logic sel,
  output logic stallm,
  output logic we2,
  output logic we3,
  output logic memwr,
  output logic memrd,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TAG    = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_REFILL = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             served1_r, served2_r, served1_s, served2_s;
  logic             sel_s, next_sel_s;
  logic             req1_s, req2_s, store_s, other_pend_s;

  assign req1_s  = memtoregm | memwritem;
  assign req2_s  = memtoregm2 | memwritem2;
  assign store_s = sel ? memwritem2 : memwritem;

  // After a lane finishes, hand the lookup port to the other lane if it still waits.
  assign other_pend_s = sel ? (req1_s & ~served1_r) : (req2_s & ~served2_r);
  assign next_state_s = other_pend_s ? S_TAG : S_DONE;
  assign next_sel_s   = other_pend_s ? ~sel : sel;

  // Reset gates stallm so every output is low while reset is held.
  assign stallm = (req1_s | req2_s) & (state_r != S_DONE) & ~reset;

  // Next-state, counter, lane-select and served-flag logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    sel_s     = sel;
    served1_s = served1_r;
    served2_s = served2_r;
    case (state_r)
      S_IDLE: begin
        if (req1_s | req2_s) begin
          state_s = S_TAG;
          sel_s   = ~req1_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_TAG: begin
        if (hit) begin
          if (store_s) begin
            state_s = S_WRITE;
          end else begin
            state_s   = next_state_s;
            sel_s     = next_sel_s;
            served1_s = served1_r | ~sel;
            served2_s = served2_r | sel;
          end
        end else if (dirty) begin
          state_s = S_WB;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = S_FILL;
          cnt_s   = CNT_LOAD;
        end
      end
      S_WB: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_FILL;
          cnt_s   = CNT_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_FILL: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_REFILL;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_REFILL: begin
        state_s = S_TAG;
      end
      S_WRITE: begin
        state_s   = next_state_s;
        sel_s     = next_sel_s;
        served1_s = served1_r | ~sel;
        served2_s = served2_r | sel;
      end
      S_DONE: begin
        state_s   = S_IDLE;
        served1_s = 1'b0;
        served2_s = 1'b0;
      end
      default: begin
        state_s   = S_IDLE;
        cnt_s     = CNT_ZERO;
        served1_s = 1'b0;
        served2_s = 1'b0;
      end
    endcase
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= CNT_ZERO;
      served1_r <= 1'b0;
      served2_r <= 1'b0;
      sel       <= 1'b0;
      busy      <= 1'b0;
      memwr     <= 1'b0;
      memrd     <= 1'b0;
      we2       <= 1'b0;
      we3       <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      served1_r <= served1_s;
      served2_r <= served2_s;
      sel       <= sel_s;
      busy      <= (state_s != S_IDLE);
      memwr     <= (state_s == S_WB);
      memrd     <= (state_s == S_FILL);
      we2       <= (state_s == S_REFILL);
      we3       <= (state_s == S_WRITE);
    end
  end

endmodule

// File: tb/tb_dcache_mem_sequencer.sv
// Bench for dcache_mem_sequencer: table-driven scenarios, a mid-writeback reset and
// randomized transactions against a lane-level cycle model, on MEM_LAT=20 and MEM_LAT=4.
module tb_dcache_mem_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] m2r1, mw1, m2r2, mw2, hit, dirty;
  logic [1:0] sel, stallm, we2, we3, memwr, memrd, busy;

  // Responder state: per instance, bit 0 = lane 1, bit 1 = lane 2.
  logic [1:0] hit0   [2];
  logic [1:0] dirty0 [2];
  logic       same   [2];
  logic [1:0] filled [2];

  int checks = 0;
  int errors = 0;

  dcache_mem_sequencer #(.MEM_LAT(20), .CNT_W(6)) dut0 (
    .clk(clk), .reset(reset),
    .memtoregm(m2r1[0]), .memwritem(mw1[0]), .memtoregm2(m2r2[0]), .memwritem2(mw2[0]),
    .hit(hit[0]), .dirty(dirty[0]),
    .sel(sel[0]), .stallm(stallm[0]), .we2(we2[0]), .we3(we3[0]),
    .memwr(memwr[0]), .memrd(memrd[0]), .busy(busy[0])
  );

  dcache_mem_sequencer #(.MEM_LAT(4), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset),
    .memtoregm(m2r1[1]), .memwritem(mw1[1]), .memtoregm2(m2r2[1]), .memwritem2(mw2[1]),
    .hit(hit[1]), .dirty(dirty[1]),
    .sel(sel[1]), .stallm(stallm[1]), .we2(we2[1]), .we3(we3[1]),
    .memwr(memwr[1]), .memrd(memrd[1]), .busy(busy[1])
  );

  // Cache tag responder: a line hits once it was refilled (both lanes if same line).
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      hit[k]   = hit0[k][sel[k]] | filled[k][sel[k]];
      dirty[k] = dirty0[k][sel[k]];
    end
  end

  // Track refills within one transaction.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!busy[k]) filled[k] <= 2'b00;
      else if (we2[k]) filled[k] <= same[k] ? 2'b11 : (filled[k] | (2'b01 << sel[k]));
    end
  end

  typedef struct packed {
    logic sel_v; logic sel; logic stallm; logic we2; logic we3; logic memwr; logic memrd; logic busy;
  } cyc_t;
  cyc_t expq[$];

  task automatic add(input logic sv, input logic s, input logic stl, input logic w2,
                     input logic w3, input logic mw, input logic mr, input logic b);
    cyc_t c;
    c = '{sv, s, stl, w2, w3, mw, mr, b};
    expq.push_back(c);
  endtask

  // Lane-level model: expand each served lane into its lookup/burst/write phases.
  task automatic build_model(input int lat, input logic [1:0] r, input logic [1:0] st,
                             input logic [1:0] h, input logic [1:0] d, input logic sm);
    logic missed0, he, lane;
    missed0 = 1'b0;
    lane = 1'b0;
    expq.delete();
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      if (r[L]) begin
        lane = (L == 1);
        he = h[L] | (lane & sm & missed0);
        add(1'b1, lane, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (!he) begin
          if (!lane) missed0 = 1'b1;
          if (d[L]) repeat (lat) add(1'b1, lane, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
          repeat (lat) add(1'b1, lane, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
          add(1'b1, lane, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          add(1'b1, lane, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (st[L]) add(1'b1, lane, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      end
    end
    add(1'b1, lane, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Closed-form stall latency from the per-lane cost rules.
  function automatic int stall_formula(input int lat, input logic r1, input logic st1,
      input logic r2, input logic st2, input logic h1, input logic d1,
      input logic h2, input logic d2, input logic sm);
    int t;
    logic he2;
    t = 0;
    he2 = h2 | (sm & r1 & ~h1);
    if (r1) t += 2 + (st1 ? 1 : 0) + (h1 ? 0 : (d1 ? 2 * lat : lat) + 2);
    if (r2) t += 2 + (st2 ? 1 : 0) + (he2 ? 0 : (d2 ? 2 * lat : lat) + 2);
    if (r1 && r2) t -= 1;
    return t;
  endfunction

  task automatic run_txn(input int k, input logic r1, input logic st1, input logic r2,
      input logic st2, input logic h1, input logic d1, input logic h2, input logic d2,
      input logic sm, output int n_stall, output int n_wr, output int n_rd,
      output int n_w2, output int n_w3);
    int lat, bad_at, excl, want;
    cyc_t e;
    logic [6:0] act, expv;
    lat = (k == 1) ? 4 : 20;
    build_model(lat, {r2, r1}, {st2, st1}, {h2, h1}, {d2, d1}, sm);
    want = stall_formula(lat, r1, st1, r2, st2, h1, d1, h2, d2, sm);
    hit0[k] = {h2, h1};
    dirty0[k] = {d2, d1};
    same[k] = sm;
    n_stall = 0; n_wr = 0; n_rd = 0; n_w2 = 0; n_w3 = 0;
    bad_at = -1; excl = 0; act = 7'd0; expv = 7'd0;
    @(negedge clk);
    m2r1[k] = r1 & ~st1; mw1[k] = r1 & st1;
    m2r2[k] = r2 & ~st2; mw2[k] = r2 & st2;
    #1;
    for (int i = 0; i < expq.size(); i++) begin
      if (i > 0) @(negedge clk);
      e = expq[i];
      if (!((busy[k] == e.busy) && (stallm[k] == e.stallm) && (we2[k] == e.we2) &&
            (we3[k] == e.we3) && (memwr[k] == e.memwr) && (memrd[k] == e.memrd) &&
            (!e.sel_v || (sel[k] == e.sel))) && (bad_at < 0)) begin
        bad_at = i;
        act = {sel[k], stallm[k], we2[k], we3[k], memwr[k], memrd[k], busy[k]};
        expv = {e.sel, e.stallm, e.we2, e.we3, e.memwr, e.memrd, e.busy};
      end
      n_stall += stallm[k]; n_wr += memwr[k]; n_rd += memrd[k];
      n_w2 += we2[k]; n_w3 += we3[k];
      if ((32'(we2[k]) + 32'(we3[k]) + 32'(memwr[k]) + 32'(memrd[k])) > 1) excl++;
    end
    checks++;
    if (bad_at >= 0) begin
      errors++;
      $display("FAIL trace k=%0d cycle %0d sel/stall/we2/we3/wr/rd/busy got %b want %b",
               k, bad_at, act, expv);
    end
    checks++;
    if (excl != 0) begin
      errors++;
      $display("FAIL excl k=%0d overlapping enable cycles got %0d want 0", k, excl);
    end
    checks++;
    if (n_stall != want) begin
      errors++;
      $display("FAIL stall_formula k=%0d got %0d want %0d", k, n_stall, want);
    end
    @(negedge clk);
    m2r1[k] = 1'b0; mw1[k] = 1'b0; m2r2[k] = 1'b0; mw2[k] = 1'b0;
    #1;
    checks++;
    if (busy[k] !== 1'b0 || stallm[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle k=%0d busy/stall got %b%b want 00", k, busy[k], stallm[k]);
    end
  endtask

  typedef struct {
    int k; logic r1, st1, r2, st2, h1, d1, h2, d2, sm;
    int stall, wr, rd, w2, w3;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int ns, nw, nr, n2, n3;
    logic r1, r2, sm, h1, h2;

    vecs[0] = '{0, 1'b1,1'b0, 1'b0,1'b0, 1'b1,1'b0, 1'b0,1'b0, 1'b0,  2,  0,  0, 0, 0};
    vecs[1] = '{0, 1'b1,1'b1, 1'b0,1'b0, 1'b0,1'b1, 1'b0,1'b0, 1'b0, 45, 20, 20, 1, 1};
    vecs[2] = '{0, 1'b1,1'b0, 1'b1,1'b1, 1'b1,1'b0, 1'b0,1'b0, 1'b0, 26,  0, 20, 1, 1};
    vecs[3] = '{0, 1'b0,1'b0, 1'b1,1'b0, 1'b0,1'b0, 1'b0,1'b0, 1'b0, 24,  0, 20, 1, 0};
    vecs[4] = '{1, 1'b1,1'b0, 1'b0,1'b0, 1'b0,1'b1, 1'b0,1'b0, 1'b0, 12,  4,  4, 1, 0};
    vecs[5] = '{0, 1'b1,1'b0, 1'b1,1'b1, 1'b0,1'b0, 1'b0,1'b0, 1'b1, 26,  0, 20, 1, 1};
    vecs[6] = '{1, 1'b1,1'b1, 1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 1'b0,  5,  0,  0, 0, 2};

    m2r1 = 2'b01; mw1 = 2'b00; m2r2 = 2'b00; mw2 = 2'b00;
    for (int k = 0; k < 2; k++) begin
      hit0[k] = 2'b00; dirty0[k] = 2'b00; same[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({sel, stallm, we2, we3, memwr, memrd, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0", {sel, stallm, we2, we3, memwr, memrd, busy});
    end
    m2r1 = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].k, vecs[v].r1, vecs[v].st1, vecs[v].r2, vecs[v].st2, vecs[v].h1,
              vecs[v].d1, vecs[v].h2, vecs[v].d2, vecs[v].sm, ns, nw, nr, n2, n3);
      checks++;
      if (ns != vecs[v].stall || nw != vecs[v].wr || nr != vecs[v].rd ||
          n2 != vecs[v].w2 || n3 != vecs[v].w3) begin
        errors++;
        $display("FAIL vec%0d stall/wr/rd/we2/we3 got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                 v, ns, nw, nr, n2, n3, vecs[v].stall, vecs[v].wr, vecs[v].rd,
                 vecs[v].w2, vecs[v].w3);
      end
    end

    // Reset in the tenth writeback cycle of a dirty lane-1 load miss.
    hit0[0] = 2'b00; dirty0[0] = 2'b01; same[0] = 1'b0;
    @(negedge clk);
    m2r1[0] = 1'b1;
    repeat (11) @(negedge clk);
    checks++;
    if (memwr[0] !== 1'b1 || stallm[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL wb_mid wr/stall/busy got %b%b%b want 111", memwr[0], stallm[0], busy[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sel[0], stallm[0], we2[0], we3[0], memwr[0], memrd[0], busy[0]} !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid got %b want 0",
               {sel[0], stallm[0], we2[0], we3[0], memwr[0], memrd[0], busy[0]});
    end
    m2r1[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_txn(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ns, nw, nr, n2, n3);
    checks++;
    if (ns != 2) begin
      errors++;
      $display("FAIL post_rst stall got %0d want 2", ns);
    end

    for (int t = 0; t < 40; t++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      if (!r1 && !r2) r2 = 1'b1;
      sm = r1 & r2 & 1'($urandom_range(0, 1));
      h1 = 1'($urandom_range(0, 1));
      h2 = sm ? h1 : 1'($urandom_range(0, 1));
      run_txn(int'($urandom_range(0, 1)), r1, 1'($urandom_range(0, 1)), r2,
              1'($urandom_range(0, 1)), h1, 1'($urandom_range(0, 1)), h2,
              1'($urandom_range(0, 1)), sm, ns, nw, nr, n2, n3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
